// File: rtl/alu_opnd_stage.sv
// Operand-select/decode stage for the ALU adder: extends imm, picks operand B and sets sub/c_in.
// Latency: 1 cycle from accept to out_valid; sustains 1 op/cycle with out_ready held high.
// Backpressure: 2-entry skid buffer; in_ready is registered (!skid full), no path from out_ready.
module alu_opnd_stage #(
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic [IMM_W-1:0] imm,
    input  logic             use_imm,
    input  logic             imm_zext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      a,
    output logic [31:0]      b,
    output logic             sub,
    output logic             c_in,
    output logic [2:0]       op_q,
    output logic             illegal
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_SLT  = 3'd2;
    localparam logic [2:0] OP_SLTU = 3'd3;
    localparam logic [2:0] OP_NEG  = 3'd4;
    localparam logic [2:0] OP_PASS = 3'd5;

    // One decoded operation as handed to the adder.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        c_in;
        logic [2:0]  op;
        logic        illegal;
    } opnd_t;

    opnd_t       dec_dat;
    opnd_t       main_dat;
    opnd_t       skid_dat;
    logic        main_vld;
    logic        skid_vld;
    logic        skid_vld_nxt;
    logic        in_rdy_q;
    logic        accept;
    logic        drain;
    logic [31:0] imm_ext;
    logic [31:0] opnd_b;

    assign accept = in_valid & in_rdy_q;
    assign drain  = main_vld & out_ready;

    // Immediate extension and second-operand select.
    always_comb begin
        imm_ext = imm_zext ? {{(32-IMM_W){1'b0}}, imm}
                           : {{(32-IMM_W){imm[IMM_W-1]}}, imm};
        opnd_b  = use_imm ? imm_ext : rt_val;
    end

    // Decode the incoming op into adder controls; illegal ops behave as ADD and are flagged.
    always_comb begin
        dec_dat         = '0;
        dec_dat.a       = rs_val;
        dec_dat.b       = opnd_b;
        dec_dat.op      = op;
        case (op)
            OP_ADD:                dec_dat.sub = 1'b0;
            OP_SUB, OP_SLT, OP_SLTU: dec_dat.sub = 1'b1;
            OP_NEG: begin
                dec_dat.a   = 32'd0;
                dec_dat.b   = rs_val;
                dec_dat.sub = 1'b1;
            end
            OP_PASS:               dec_dat.b = 32'd0;
            default:               dec_dat.illegal = 1'b1;
        endcase
        // The adder's +1 for two's-complement subtraction comes in through the carry.
        dec_dat.c_in = dec_dat.sub;
    end

    // Skid occupancy next cycle: fills only when main is stuck and a new op arrives.
    always_comb begin
        if (skid_vld)
            skid_vld_nxt = ~drain;
        else
            skid_vld_nxt = main_vld & ~drain & accept;
    end

    // Main/skid registers; skid always refills main first so order is preserved.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            in_rdy_q <= 1'b0;
            main_dat <= '0;
            skid_dat <= '0;
        end else begin
            skid_vld <= skid_vld_nxt;
            in_rdy_q <= ~skid_vld_nxt;
            if (skid_vld) begin
                if (drain)
                    main_dat <= skid_dat;
            end else if (!main_vld || drain) begin
                main_vld <= accept;
                if (accept)
                    main_dat <= dec_dat;
            end else if (accept) begin
                skid_dat <= dec_dat;
            end
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = main_vld;
    assign a         = main_dat.a;
    assign b         = main_dat.b;
    assign sub       = main_dat.sub;
    assign c_in      = main_dat.c_in;
    assign op_q      = main_dat.op;
    assign illegal   = main_dat.illegal;

endmodule

// File: tb/tb_alu_opnd_stage.sv
// Bench for alu_opnd_stage: directed steps plus random streaming against a scoreboard.
// Latency: expectations assume 1-cycle accept-to-out_valid.
// Backpressure: out_ready is toggled to exercise the skid path and hold behaviour.
module tb_alu_opnd_stage;

    localparam int IMM_W = 16;

    logic             clk = 1'b0;
    logic             clrn;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [31:0]      rs_val;
    logic [31:0]      rt_val;
    logic [IMM_W-1:0] imm;
    logic             use_imm;
    logic             imm_zext;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      a;
    logic [31:0]      b;
    logic             sub;
    logic             c_in;
    logic [2:0]       op_q;
    logic             illegal;

    int errors = 0;
    int checks = 0;
    logic [69:0] exp_q[$];

    alu_opnd_stage #(.IMM_W(IMM_W)) dut (
        .clk(clk), .clrn(clrn),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
        .use_imm(use_imm), .imm_zext(imm_zext),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .sub(sub), .c_in(c_in), .op_q(op_q), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference: expected {a, b, sub, c_in, op, illegal} from the op table with plain arithmetic.
    function automatic logic [69:0] model(input logic [2:0] op_i, input logic [31:0] rs_i,
                                          input logic [31:0] rt_i, input logic [IMM_W-1:0] imm_i,
                                          input logic use_imm_i, input logic zext_i);
        longint unsigned opb;
        logic [31:0] ea, eb;
        logic es, eill;
        if (!use_imm_i)
            opb = 64'(rt_i);
        else if (zext_i || (64'(imm_i) < (64'd1 << (IMM_W - 1))))
            opb = 64'(imm_i);
        else
            opb = 64'(imm_i) + (64'd1 << 32) - (64'd1 << IMM_W);
        ea = rs_i; eb = opb[31:0]; es = 1'b0; eill = 1'b0;
        if (op_i == 3'd1 || op_i == 3'd2 || op_i == 3'd3) es = 1'b1;
        else if (op_i == 3'd4) begin ea = 32'd0; eb = rs_i; es = 1'b1; end
        else if (op_i == 3'd5) eb = 32'd0;
        else if (op_i >= 3'd6) eill = 1'b1;
        return {ea, eb, es, es, op_i, eill};
    endfunction

    function automatic logic [69:0] obs_vec();
        return {a, b, sub, c_in, op_q, illegal};
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [IMM_W-1:0] im, input logic ui, input logic zx);
        op = o; rs_val = rs; rt_val = rt; imm = im; use_imm = ui; imm_zext = zx;
    endtask

    task automatic set_rand();
        set_op(3'($urandom_range(0, 7)), $urandom, $urandom, IMM_W'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // One clock: score the transfers that happen at the coming edge, then advance.
    task automatic step();
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", 70'd1, 70'd0);
            else chk("out_order", obs_vec(), exp_q.pop_front());
        end
        if (in_valid && in_ready)
            exp_q.push_back(model(op, rs_val, rt_val, imm, use_imm, imm_zext));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] sum;
        clrn = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_op(3'd0, 32'd0, 32'd0, '0, 1'b0, 1'b0);

        // Reset state, asynchronously applied.
        #1 clrn = 1'b0;
        #2;
        chk("rst_out_valid", 70'(out_valid), 70'd0);
        chk("rst_in_ready", 70'(in_ready), 70'd0);
        chk("rst_outputs", obs_vec(), 70'd0);
        @(posedge clk); @(posedge clk); #1;
        clrn = 1'b1;
        chk("rel_in_ready_low", 70'(in_ready), 70'd0);
        step();
        chk("rel_in_ready_high", 70'(in_ready), 70'd1);

        // ADD 5 + 3 with register operand.
        out_ready = 1'b1; in_valid = 1'b1;
        set_op(3'd0, 32'h5, 32'h3, '0, 1'b0, 1'b0);
        step();
        chk("add_valid", 70'(out_valid), 70'd1);
        chk("add_fields", {a, b, sub, c_in}, {32'd5, 32'd3, 1'b0, 1'b0});

        // SUB with sign- then zero-extended 0xFFFF immediate.
        set_op(3'd1, 32'h10, 32'h0, 16'hFFFF, 1'b1, 1'b0);
        step();
        chk("sub_sext", {b, sub, c_in}, {32'hFFFFFFFF, 1'b1, 1'b1});
        set_op(3'd1, 32'h10, 32'h0, 16'hFFFF, 1'b1, 1'b1);
        step();
        chk("sub_zext", {b, sub, c_in}, {32'h0000FFFF, 1'b1, 1'b1});

        // NEG 1 and the downstream adder result.
        set_op(3'd4, 32'h1, 32'h12345678, '0, 1'b0, 1'b0);
        step();
        chk("neg_fields", {a, b, sub, c_in}, {32'd0, 32'd1, 1'b1, 1'b1});
        sum = a + (b ^ {32{sub}}) + 32'(c_in);
        chk("neg_adder", 70'(sum), 70'(32'hFFFFFFFF));
        in_valid = 1'b0;
        step();
        chk("idle_valid", 70'(out_valid), 70'd0);
        chk("idle_q_empty", 70'(exp_q.size()), 70'd0);

        // Backpressure: three ops offered with out_ready low.
        out_ready = 1'b0; in_valid = 1'b1;
        set_rand();
        chk("bp_rdy1", 70'(in_ready), 70'd1);
        step();
        set_rand();
        chk("bp_rdy2", 70'(in_ready), 70'd1);
        step();
        set_rand();
        chk("bp_rdy_cycle3", 70'(in_ready), 70'd0);
        chk("bp_valid", 70'(out_valid), 70'd1);
        step();
        chk("bp_hold", obs_vec(), exp_q[0]);
        chk("bp_still_full", 70'(in_ready), 70'd0);
        out_ready = 1'b1;
        step();
        chk("bp_rdy_back", 70'(in_ready), 70'd1);
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("bp_drained", 70'(exp_q.size()), 70'd0);
        chk("bp_idle", 70'(out_valid), 70'd0);

        // Random streaming at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_rand();
            in_valid = 1'b1;
            chk("stream_in_ready", 70'(in_ready), 70'd1);
            if (i > 0) chk("stream_out_valid", 70'(out_valid), 70'd1);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", 70'(exp_q.size()), 70'd0);
        chk("stream_idle", 70'(out_valid), 70'd0);

        // Reset with both entries full and stalled output.
        out_ready = 1'b0; in_valid = 1'b1;
        set_rand();
        step();
        set_rand();
        step();
        in_valid = 1'b0;
        chk("full_before_rst", 70'(in_ready), 70'd0);
        #2 clrn = 1'b0;
        #1;
        chk("midrst_valid", 70'(out_valid), 70'd0);
        chk("midrst_in_ready", 70'(in_ready), 70'd0);
        chk("midrst_outputs", obs_vec(), 70'd0);
        exp_q.delete();
        @(posedge clk); #1;
        clrn = 1'b1;
        out_ready = 1'b1;
        chk("midrst_rel_rdy_low", 70'(in_ready), 70'd0);
        step();
        chk("midrst_rel_rdy_high", 70'(in_ready), 70'd1);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_stale", 70'(out_valid), 70'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
